tick_serial_tx: RTL



---
 rtl/tick_serial_tx_pkg.sv | 16 +
 rtl/tick_serial_tx_if.sv | 24 ++
 rtl/tick_serial_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tick_serial_tx_pkg.sv
// Shared definitions for the tick-paced serial transmitter: state encoding and line levels.
package tick_serial_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/tick_serial_tx_if.sv
// Word handoff, bit strobe and serial/status lines between upstream logic and the transmitter.
interface tick_serial_tx_if #(
  parameter int DATA_BITS = 8
);

  logic                 Tick;
  logic [DATA_BITS-1:0] DataIn;
  logic                 Load;
  logic                 Ready;
  logic                 SerialOut;
  logic                 Busy;
  logic                 Done;

  modport master (
    output Tick, DataIn, Load,
    input  Ready, SerialOut, Busy, Done
  );

  modport slave (
    input  Tick, DataIn, Load,
    output Ready, SerialOut, Busy, Done
  );

endinterface

// File: rtl/tick_serial_tx.sv
// Serial transmitter paced by an external one-cycle Tick: start, data LSB-first, optional parity, stop.
module tick_serial_tx
  import tick_serial_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input logic             Clock,
  input logic             Reset,
  tick_serial_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 stop_left, stop_left_n;
  logic                 so, so_n;
  logic                 done, done_n;
  logic                 ready, busy;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stop_left <= 1'b0;
      so        <= LINE_IDLE;
      done      <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stop_left <= stop_left_n;
      so        <= so_n;
      done      <= done_n;
      ready     <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
    end
  end

  // Word and parity only matter once a frame is accepted, so they carry no reset.
  always_ff @(posedge Clock) begin
    shreg <= shreg_n;
    par   <= par_n;
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    par_n       = par;
    cnt_n       = cnt;
    stop_left_n = stop_left;
    so_n        = so;
    done_n      = 1'b0;
    case (state)
      S_IDLE: begin
        so_n = LINE_IDLE;
        if (bus.Load) begin
          shreg_n = bus.DataIn;
          par_n   = (^bus.DataIn) ^ (PARITY_ODD != 0);
          cnt_n   = '0;
          state_n = S_ARM;
        end
      end
      // A Tick in the Load cycle is ignored so the start bit always spans a full period.
      S_ARM: begin
        if (bus.Tick) begin
          so_n    = START_BIT;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bus.Tick) begin
          so_n    = shreg[0];
          shreg_n = shreg >> 1;
          cnt_n   = CNT_W'(1);
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.Tick) begin
          if (cnt == CNT_W'(DATA_BITS)) begin
            if (PARITY_EN != 0) begin
              so_n    = par;
              state_n = S_PARITY;
            end else begin
              so_n        = LINE_IDLE;
              stop_left_n = (STOP_BITS == 2);
              state_n     = S_STOP;
            end
          end else begin
            so_n    = shreg[0];
            shreg_n = shreg >> 1;
            cnt_n   = cnt + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bus.Tick) begin
          so_n        = LINE_IDLE;
          stop_left_n = (STOP_BITS == 2);
          state_n     = S_STOP;
        end
      end
      S_STOP: begin
        if (bus.Tick) begin
          if (stop_left) begin
            stop_left_n = 1'b0;
          end else begin
            cnt_n   = '0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        so_n    = LINE_IDLE;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.Ready     = ready;
  assign bus.Busy      = busy;
  assign bus.SerialOut = so;
  assign bus.Done      = done;

endmodule
